// File: rtl/uart_tx_core_if.sv
// Producer-side handshake bundle for uart_tx_core: valid/data offered, ready
// returned when the transmit FIFO has room.
interface uart_tx_core_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: small FIFO feeding a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to add the parity bit (odd/even chosen by parity_odd).
module uart_tx_core #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_core_if.slave                 bus,
  input  logic                          parity_odd,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = $clog2(DATA_W);

  localparam logic [BW-1:0] BAUD_TC  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STP = IW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------- transmit FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              ready_en;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  assign bus.tx_ready = ready_en && (count != FULL);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign head         = mem[rd_ptr];
  assign fifo_count   = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // ready_en keeps the handshake closed while reset is held and opens it on
  // the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- serialiser ----------------
  state_t            state, state_d;
  logic [BW-1:0]     baud, baud_d;
  logic [IW-1:0]     bit_idx, bit_idx_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              tx_d;
  logic              baud_tc;
  logic              fifo_nonempty;

  assign baud_tc       = (baud == BAUD_TC);
  assign fifo_nonempty = (count != '0);
  assign busy          = (state != IDLE) || fifo_nonempty;

`ifdef UART_TX_PARITY_EN
  logic par, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        if (baud_tc) state_d = DATA;
      end
      DATA: begin
        if (baud_tc && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tc) state_d = STOP;
      end
`endif
      STOP: begin
        // Back-to-back frames: the next word is popped on the closing edge.
        if (baud_tc && (bit_idx == LAST_STP)) begin
          if (fifo_nonempty) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line changes on the
  // same edge as the state it represents.
  always_comb begin
    if ((state == IDLE) || (state_d != state) || baud_tc) baud_d = '0;
    else                                                  baud_d = baud + BW'(1);

    bit_idx_d = bit_idx;
    if (state_d != state)                                   bit_idx_d = '0;
    else if (baud_tc && ((state == DATA) || (state == STOP))) bit_idx_d = bit_idx + IW'(1);

    shreg_d = shreg;
    if (pop)                           shreg_d = head;
    else if ((state == DATA) && baud_tc) shreg_d = shreg >> 1;

`ifdef UART_TX_PARITY_EN
    par_d = pop ? ((^head) ^ parity_odd) : par;
`endif

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (>=2).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port tx_valid  input  1  producer offers tx_data.
REQ-008 SHALL have port tx_data  input  DATA_W  word to transmit.
REQ-009 SHALL have port tx_ready  output  1  FIFO can accept a word (not full).
REQ-010 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even; sampled at frame start.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL accept a word on any rising edge where tx_valid && tx_ready; words are never dropped or duplicated.
REQ-015 SHALL deassert tx_ready exactly when fifo_count == FIFO_DEPTH.
REQ-016 SHALL, on a simultaneous push and pop, leave fifo_count unchanged; push when full is ignored by the handshake.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY only when enabled (REQ-029).
REQ-018 SHALL, in IDLE with FIFO non-empty, pop the head word into the shift register on the next edge and enter START; a word pushed into an empty FIFO at edge N starts its start bit at edge N+1.
REQ-019 SHALL run a baud counter 0..CLKS_PER_BIT-1, cleared on every state entry; state/bit advances only at terminal count.
REQ-020 SHALL drive tx = 0 in START, shift-register LSB in DATA (LSB first, DATA_W bits), parity bit in PARITY, 1 in STOP and IDLE.
REQ-021 SHALL hold each bit for exactly CLKS_PER_BIT cycles; frame length = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, P = 1 if parity enabled else 0.
REQ-022 SHALL, at the end of the last stop bit with FIFO non-empty, pop and enter START on the same edge (no idle gap); with FIFO empty, enter IDLE.
REQ-023 SHALL compute parity over the latched DATA_W word: even = XOR of bits, odd = inverted XOR; parity_odd changes mid-frame have no effect.
REQ-024 SHALL register tx (glitch-free output from a flop).
REQ-025 SHALL assert busy whenever state != IDLE or fifo_count != 0.

Reset
REQ-026 SHALL, on reset assertion, asynchronously force tx = 1, state IDLE, baud counter 0, fifo_count 0, busy 0, FIFO pointers 0.
REQ-027 SHALL, during reset, hold tx_ready = 0; tx_ready = 1 from the first edge after reset deassertion.
REQ-028 SHALL, on reset mid-frame, abort the frame and discard all FIFO contents; no partial frame resumes.

Configuration
REQ-029 SHALL compile the PARITY state and parity bit only when macro UART_TX_PARITY_EN is defined; without it parity_odd is ignored, P = 0, and DATA -> STOP directly.

Verification (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 SHALL cover: push 0xA5 into empty FIFO, no parity, STOP_BITS=1 -> tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles total, then idle high, busy low.
REQ-031 SHALL cover: UART_TX_PARITY_EN, 0xA5 with parity_odd=0 then 1 -> parity bit 0 then 1, 44-cycle frames.
REQ-032 SHALL cover: tx_valid held high with 6 words in consecutive cycles -> 5 accepted, tx_ready low with fifo_count 4, sixth accepted only after next pop.
REQ-033 SHALL cover: two words queued, STOP_BITS=2 -> 8 stop cycles high then start bit of second word on the next cycle, no idle gap.
REQ-034 SHALL cover: reset asserted at cycle 15 of a frame with 3 words queued -> tx = 1 immediately, fifo_count 0, no further frames after release.
REQ-035 SHALL cover: simultaneous push and pop at fifo_count 2 -> fifo_count stays 2, word order preserved on tx.
